// File: rtl/bin2bcd_pkg.sv
// Shared FSM state type, active-low segment constants and the double-dabble digit step
// for the bin2bcd_seq converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // Segment patterns are written a..g left to right; bit 0 of the result is segment a.
  function automatic logic [6:0] seg_abcdefg(input logic [6:0] s);
    logic [6:0] r;
    r = '0;
    for (int unsigned i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  localparam logic [6:0] SEG_BLANK = seg_abcdefg(7'b1111111);
  localparam logic [6:0] SEG_DASH  = seg_abcdefg(7'b1111110);

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seg7_digit.sv
// One BCD digit to active-low 7-segment pattern (bit 0 = segment a).
module seg7_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (bcd_i)
      4'd0:    seg_o = seg_abcdefg(7'b0000001);
      4'd1:    seg_o = seg_abcdefg(7'b1001111);
      4'd2:    seg_o = seg_abcdefg(7'b0010010);
      4'd3:    seg_o = seg_abcdefg(7'b0000110);
      4'd4:    seg_o = seg_abcdefg(7'b1001100);
      4'd5:    seg_o = seg_abcdefg(7'b0100100);
      4'd6:    seg_o = seg_abcdefg(7'b0100000);
      4'd7:    seg_o = seg_abcdefg(7'b0001111);
      4'd8:    seg_o = seg_abcdefg(7'b0000000);
      4'd9:    seg_o = seg_abcdefg(7'b0000100);
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with start/done handshake and HEX drivers.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               oflow_q, oflow_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;
  logic [6:0]         seg_raw [DIGITS];
`ifdef LEADING_ZERO_BLANK_EN
  logic               lead;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      oflow_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      oflow_q   <= oflow_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) adj[4*k +: 4] = add3_if_ge5(scratch_q[4*k +: 4]);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    oflow_d   = oflow_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Bits leaving the top digit are dropped, so bcd keeps value mod 10^DIGITS.
        scratch_d = {adj[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d   = shift_q << 1;
        ovf_d     = ovf_q | adj[BCD_W-1];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        oflow_d = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign overflow = oflow_q;
  assign bcd_out  = bcd_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit u_seg (
      .bcd_i (bcd_q[4*g +: 4]),
      .seg_o (seg_raw[g])
    );
  end

  always_comb begin
    hex_out = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
`endif
    for (int unsigned i = DIGITS; i > 0; i--) begin
      if (oflow_q) begin
        hex_out[7*(i-1) +: 7] = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
      end else if (lead && (i != 1) && (bcd_q[4*(i-1) +: 4] == 4'd0)) begin
        hex_out[7*(i-1) +: 7] = SEG_BLANK;
      end else begin
        hex_out[7*(i-1) +: 7] = seg_raw[i-1];
        lead = 1'b0;
      end
`else
      end else begin
        hex_out[7*(i-1) +: 7] = seg_raw[i-1];
      end
`endif
    end
  end

endmodule
